// File: rtl/axis_burst_receiver.sv
// axis_burst_receiver
//   AXI4-Stream slave that captures one burst of up to DEPTH words into a
//   register buffer when armed by enable. The buffer is then read through
//   a registered indexed read port.
//
//   Optional feature macro: AXIS_RX_TKEEP_EN
//     When defined, adds s_axis_tkeep. Byte lanes with tkeep=0 are stored
//     as 8'h00. When undefined, all byte lanes are stored as received.
//
// Ports
//   aclk, aresetn   clock, asynchronous active-low reset
//   enable          level: arm receiver; deassert to release done
//   s_axis_*        stream slave (tdata, tvalid, tready, tlast[, tkeep])
//   rd_index        buffer read address
//   rd_data         buffer word at rd_index, one cycle later
//   count           words captured in the current/last burst (0..DEPTH)
//   done            burst captured, buffer stable
//   len_err         DEPTH words taken without tlast
module axis_burst_receiver #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  enable,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
`ifdef AXIS_RX_TKEEP_EN
  input  logic [DATA_WIDTH/8-1:0] s_axis_tkeep,
`endif
  input  logic [ADDR_WIDTH-1:0] rd_index,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  done,
  output logic                  len_err
);

  typedef enum logic [1:0] {
    IDLE,
    RECV,
    DONE
  } state_t;

  localparam logic [ADDR_WIDTH:0] LAST_SLOT = (ADDR_WIDTH+1)'(DEPTH - 1);

  state_t state, state_next;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] wdata;
  logic                  accept;
  logic                  last_beat;

  // tready is only ever high in RECV, so accept implies state==RECV.
  assign accept    = s_axis_tvalid && s_axis_tready;
  assign last_beat = accept && (s_axis_tlast || (count == LAST_SLOT));

  always_comb begin
    wdata = s_axis_tdata;
`ifdef AXIS_RX_TKEEP_EN
    for (int unsigned b = 0; b < DATA_WIDTH/8; b++) begin
      if (!s_axis_tkeep[b]) wdata[b*8 +: 8] = '0;
    end
`endif
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (enable)    state_next = RECV;
      RECV:    if (last_beat) state_next = DONE;
      DONE:    if (!enable)   state_next = IDLE;
      default:                state_next = IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) state <= IDLE;
    else          state <= state_next;
  end

  // tready/done are registered images of the next state, so they change on
  // the same edge as the state and never depend combinationally on inputs.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      s_axis_tready <= 1'b0;
      done          <= 1'b0;
      count         <= '0;
      len_err       <= 1'b0;
      rd_data       <= '0;
    end else begin
      s_axis_tready <= (state_next == RECV);
      done          <= (state_next == DONE);
      rd_data       <= mem[rd_index];
      if (state == IDLE && enable) begin
        count   <= '0;
        len_err <= 1'b0;
      end else if (accept) begin
        count <= count + (ADDR_WIDTH+1)'(1);
        if (count == LAST_SLOT && !s_axis_tlast) len_err <= 1'b1;
      end
    end
  end

  // Buffer contents are deliberately not reset.
  always_ff @(posedge aclk) begin
    if (accept) mem[count[ADDR_WIDTH-1:0]] <= wdata;
  end

endmodule

// File: tb/tb_axis_burst_receiver.sv
// tb_axis_burst_receiver
//   Self-checking bench for axis_burst_receiver: a table of directed bursts,
//   hand-written reset / DONE-hold sequences and randomized bursts, all
//   checked against a burst-level reference model (expected length, error
//   flag and buffer image computed from the tlast position).
module tb_axis_burst_receiver;

  localparam int DW    = 32;
  localparam int DEPTH = 8;
  localparam int AW    = 3;
  localparam int unsigned NONE = 99;

  logic          aclk = 1'b0;
  logic          aresetn;
  logic          enable;
  logic [DW-1:0] s_axis_tdata;
  logic          s_axis_tvalid;
  logic          s_axis_tready;
  logic          s_axis_tlast;
  logic [3:0]    keep = 4'hF;
  logic [AW-1:0] rd_index;
  logic [DW-1:0] rd_data;
  logic [AW:0]   count;
  logic          done;
  logic          len_err;

  int unsigned checks = 0;
  int unsigned fails  = 0;

  logic [DW-1:0] mbuf   [DEPTH];
  bit            mvalid [DEPTH];

  always #5 aclk = ~aclk;

  axis_burst_receiver #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .enable        (enable),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tlast  (s_axis_tlast),
`ifdef AXIS_RX_TKEEP_EN
    .s_axis_tkeep  (keep),
`endif
    .rd_index      (rd_index),
    .rd_data       (rd_data),
    .count         (count),
    .done          (done),
    .len_err       (len_err)
  );

  typedef struct {
    int unsigned len;
    int unsigned last_pos;
    logic [31:0] base;
    bit          gaps;
    int unsigned exp_count;
    bit          exp_err;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] apply_keep(input logic [31:0] d, input logic [3:0] k);
    logic [31:0] r;
    r = d;
`ifdef AXIS_RX_TKEEP_EN
    for (int unsigned b = 0; b < 4; b++) if (!k[b]) r[b*8 +: 8] = 8'h00;
`else
    if (k == 4'h0) r = d;
`endif
    return r;
  endfunction

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic readback_all();
    for (int unsigned i = 0; i < DEPTH; i++) begin
      rd_index = AW'(i);
      tick();
      if (mvalid[i]) chk($sformatf("rd_data[%0d]", i), rd_data, mbuf[i]);
    end
  endtask

  task automatic release_done();
    enable = 1'b0;
    tick();
    chk("release_done", done, 1'b0);
    chk("release_tready", s_axis_tready, 1'b0);
  endtask

  task automatic run_burst(input int unsigned len, input int unsigned last_pos,
                           input logic [31:0] base, input bit gaps, input bit arm,
                           output int unsigned mcount, output bit merr);
    logic [31:0] w [16];
    bit          l [16];
    int unsigned idx, budget;
    bit          found;
    logic        r;
    for (int unsigned i = 0; i < 16; i++) begin
      w[i] = base + i;
      l[i] = (i == last_pos);
    end
    // Reference: burst ends at first tlast within DEPTH words, else at DEPTH with error.
    mcount = DEPTH;
    merr   = 1'b1;
    found  = 1'b0;
    for (int unsigned i = 0; i < len && i < DEPTH; i++) begin
      if (l[i] && !found) begin
        mcount = i + 1;
        merr   = 1'b0;
        found  = 1'b1;
      end
    end
    for (int unsigned i = 0; i < mcount; i++) begin
      mbuf[i]   = apply_keep(w[i], keep);
      mvalid[i] = 1'b1;
    end

    if (arm) begin
      enable = 1'b1;
      tick();
      chk("arm_tready", s_axis_tready, 1'b1);
      chk("arm_count", count, 0);
      chk("arm_done", done, 1'b0);
      chk("arm_len_err", len_err, 1'b0);
    end

    idx    = 0;
    budget = 100;
    while (idx < mcount && budget > 0) begin
      budget--;
      if (gaps && $urandom_range(0, 1) == 0) begin
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = $urandom;
        s_axis_tlast  = 1'($urandom_range(0, 1));
      end else begin
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = w[idx];
        s_axis_tlast  = l[idx];
      end
      r = s_axis_tready;
      tick();
      if (s_axis_tvalid && r) idx++;
    end
    s_axis_tvalid = 1'b0;
    chk("beats_accepted", idx, mcount);
    chk("end_tready", s_axis_tready, 1'b0);
    chk("end_done", done, 1'b1);

    // Words past the end belong to the next burst and must be refused.
    if (idx < len) begin
      for (int unsigned c = 0; c < 2; c++) begin
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = w[idx];
        s_axis_tlast  = l[idx];
        tick();
        chk("extra_tready", s_axis_tready, 1'b0);
      end
      s_axis_tvalid = 1'b0;
    end
    chk("burst_count", count, mcount);
    chk("burst_len_err", len_err, merr);
    readback_all();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int unsigned mc;
    bit          me;
    int unsigned len, lp;

    vecs[0] = '{len: 8,  last_pos: 7,    base: 32'h0,   gaps: 1'b0, exp_count: 8, exp_err: 1'b0};
    vecs[1] = '{len: 5,  last_pos: 4,    base: 32'hA0,  gaps: 1'b0, exp_count: 5, exp_err: 1'b0};
    vecs[2] = '{len: 10, last_pos: NONE, base: 32'h100, gaps: 1'b0, exp_count: 8, exp_err: 1'b1};
    vecs[3] = '{len: 8,  last_pos: 7,    base: 32'h0,   gaps: 1'b1, exp_count: 8, exp_err: 1'b0};
    vecs[4] = '{len: 9,  last_pos: 7,    base: 32'h200, gaps: 1'b1, exp_count: 8, exp_err: 1'b0};
    vecs[5] = '{len: 1,  last_pos: 0,    base: 32'h77,  gaps: 1'b0, exp_count: 1, exp_err: 1'b0};

    for (int unsigned i = 0; i < DEPTH; i++) mvalid[i] = 1'b0;
    aresetn = 1'b0; enable = 1'b0; s_axis_tvalid = 1'b0;
    s_axis_tdata = '0; s_axis_tlast = 1'b0; rd_index = '0;
    #12;
    chk("reset_tready", s_axis_tready, 1'b0);
    chk("reset_count", count, 0);
    chk("reset_done", done, 1'b0);
    chk("reset_len_err", len_err, 1'b0);
    chk("reset_rd_data", rd_data, 0);
    tick();
    aresetn = 1'b1;
    tick();

    // Directed bursts from the table.
    for (int unsigned v = 0; v < 6; v++) begin
      run_burst(vecs[v].len, vecs[v].last_pos, vecs[v].base, vecs[v].gaps, 1'b1, mc, me);
      chk($sformatf("vec%0d_count", v), count, vecs[v].exp_count);
      chk($sformatf("vec%0d_len_err", v), len_err, vecs[v].exp_err);
      release_done();
    end

    // Reset in the middle of a burst.
    enable = 1'b1;
    tick();
    for (int unsigned i = 0; i < 3; i++) begin
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = 32'h900 + i;
      s_axis_tlast  = 1'b0;
      mvalid[i]     = 1'b0;
      tick();
    end
    s_axis_tvalid = 1'b0;
    aresetn = 1'b0;
    #1;
    chk("midrst_tready", s_axis_tready, 1'b0);
    chk("midrst_count", count, 0);
    chk("midrst_done", done, 1'b0);
    chk("midrst_len_err", len_err, 1'b0);
    chk("midrst_rd_data", rd_data, 0);
    enable = 1'b0;
    tick();
    aresetn = 1'b1;
    tick();
    run_burst(4, 3, 32'h400, 1'b0, 1'b1, mc, me);
    chk("post_rst_count", count, 4);
    release_done();

    // DONE holds while enable stays high; extra beats are refused.
    run_burst(3, 2, 32'h300, 1'b0, 1'b1, mc, me);
    for (int unsigned c = 0; c < 3; c++) begin
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = 32'hDEAD0000 + c;
      s_axis_tlast  = 1'b1;
      tick();
      chk("hold_tready", s_axis_tready, 1'b0);
      chk("hold_done", done, 1'b1);
    end
    s_axis_tvalid = 1'b0;
    chk("hold_count", count, 3);
    readback_all();
    enable = 1'b0;
    tick();
    enable = 1'b1;
    tick();
    chk("rearm_count", count, 0);
    chk("rearm_done", done, 1'b0);
    chk("rearm_tready", s_axis_tready, 1'b1);
    run_burst(2, 1, 32'h310, 1'b1, 1'b0, mc, me);
    release_done();

`ifdef AXIS_RX_TKEEP_EN
    keep = 4'b0101;
    run_burst(1, 0, 32'h11223344, 1'b0, 1'b1, mc, me);
    rd_index = '0;
    tick();
    chk("tkeep_word", rd_data, 32'h00220044);
    release_done();
    keep = 4'hF;
`endif

    // Randomized bursts.
    for (int unsigned it = 0; it < 20; it++) begin
      len = $urandom_range(1, 12);
      lp  = $urandom_range(0, len);
      if (lp == len) lp = (len < DEPTH) ? len - 1 : NONE;
      run_burst(len, lp, $urandom, 1'($urandom_range(0, 1)), 1'b1, mc, me);
      release_done();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
